// File: rtl/cic_interp.sv
// cic_interp: linear-interpolating 1:8 upsampler (44.1 kHz -> 352.8 kHz).
// A comb (difference register) plus an integrator (accumulator) timed off a
// free-running phase counter; no handshake on the data path.
// Ports:
//   mclk     master clock
//   reset_n  asynchronous active-low reset
//   pcm_in   signed input sample, captured at the end of the in_req cycle
//   in_req   high for one cycle per frame (cnt == FRAME-1)
//   pcm_out  signed interpolated output, changes only on phase boundaries
//   out_stb  high for the first cycle each new pcm_out value is valid
module cic_interp #(
    parameter int unsigned PHASE_CYCLES = 128,
    parameter int unsigned RATIO_LOG2   = 3
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic [31:0] pcm_in,
    output logic        in_req,
    output logic [31:0] pcm_out,
    output logic        out_stb
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RATIO   = 1 << RATIO_LOG2;
    localparam int unsigned FRAME   = PHASE_CYCLES * RATIO;
    localparam int unsigned CNT_W   = $clog2(FRAME);
    localparam int unsigned PH_W    = $clog2(PHASE_CYCLES);
    localparam int unsigned DELTA_W = DATA_W + 1;
    localparam int unsigned ACC_W   = DATA_W + RATIO_LOG2 + 1;

    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [DATA_W-1:0]  cur_q,    cur_d;
    logic [DELTA_W-1:0] delta_q,  delta_d;
    logic [ACC_W-1:0]   acc_q,    acc_d;
    logic               out_stb_q, out_stb_d;
    logic               in_req_q,  in_req_d;
    logic               load_c;
    logic               step_c;

    // Frame / phase decode and next-state computation
    always_comb begin
        cnt_d     = cnt_q + CNT_W'(1);
        cur_d     = cur_q;
        delta_d   = delta_q;
        acc_d     = acc_q;
        out_stb_d = 1'b0;
        load_c    = (cnt_q == CNT_W'(FRAME - 1));
        step_c    = (cnt_q[PH_W-1:0] == {PH_W{1'b1}}) && !load_c;
        // in_req is registered, so decode one cycle early
        in_req_d  = (cnt_q == CNT_W'(FRAME - 2));

        if (load_c) begin
            cur_d     = pcm_in;
            delta_d   = {{(DELTA_W - DATA_W){pcm_in[DATA_W-1]}}, pcm_in}
                      - {{(DELTA_W - DATA_W){cur_q[DATA_W-1]}}, cur_q};
            // Integrator restarts at the previous sample, scaled by R
            acc_d     = {{(ACC_W - DATA_W - RATIO_LOG2){cur_q[DATA_W-1]}},
                         cur_q, {RATIO_LOG2{1'b0}}};
            out_stb_d = 1'b1;
        end else if (step_c) begin
            acc_d     = acc_q + {{(ACC_W - DELTA_W){delta_q[DELTA_W-1]}}, delta_q};
            out_stb_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            cur_q     <= '0;
            delta_q   <= '0;
            acc_q     <= '0;
            out_stb_q <= 1'b0;
            in_req_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cur_q     <= cur_d;
            delta_q   <= delta_d;
            acc_q     <= acc_d;
            out_stb_q <= out_stb_d;
            in_req_q  <= in_req_d;
        end
    end

    // Dropping the fractional bits of the accumulator is a floor division by R
    assign pcm_out = acc_q[RATIO_LOG2 +: DATA_W];
    assign out_stb = out_stb_q;
    assign in_req  = in_req_q;

endmodule
